// File: rtl/dac_dwa.sv
// rtl/dac_dwa.sv - DWA dynamic element matcher for the 15-element unary DAC
// Rotates the thermometer-selected element set from a wrapping pointer, or passes it through in bypass.
module dac_dwa #(
  parameter int UNITS = 15,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [UNITS-1:0] thermometer,
  input  logic             dwa_en,
  input  logic             ptr_clr,
  output logic [UNITS-1:0] unit_sel,
  output logic             sel_valid,
  output logic [PTR_W-1:0] ptr,
  output logic             code_err
);

  logic [1:0]         s1 [7];
  logic [2:0]         s2 [4];
  logic [3:0]         s3 [2];
  logic [PTR_W-1:0]   n;
  logic [UNITS-1:0]   mask;
  logic               malformed;
  logic [PTR_W-1:0]   p_eff;
  logic [2*UNITS-1:0] rot;
  logic [UNITS-1:0]   sel;
  logic [PTR_W:0]     sum;
  logic [PTR_W:0]     wrap;
  logic [PTR_W-1:0]   ptr_nxt;

  // Popcount as a balanced adder tree sized for exactly 15 inputs.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      s1[k] = {1'b0, thermometer[2*k]} + {1'b0, thermometer[2*k+1]};
    end
    s2[0] = {1'b0, s1[0]} + {1'b0, s1[1]};
    s2[1] = {1'b0, s1[2]} + {1'b0, s1[3]};
    s2[2] = {1'b0, s1[4]} + {1'b0, s1[5]};
    s2[3] = {1'b0, s1[6]} + {2'b00, thermometer[14]};
    s3[0] = {1'b0, s2[0]} + {1'b0, s2[1]};
    s3[1] = {1'b0, s2[2]} + {1'b0, s2[3]};
    n     = s3[0] + s3[1];
  end

  always_comb begin
    for (int i = 0; i < UNITS; i++) begin
      mask[i] = (PTR_W'(i) < n);
    end
    malformed = (thermometer != mask);
    p_eff     = ptr_clr ? '0 : ptr;
    // Shifting a double-width copy and folding the halves gives a rotate mod 15.
    rot       = {{UNITS{1'b0}}, mask} << p_eff;
    sel       = rot[UNITS-1:0] | rot[2*UNITS-1:UNITS];
    sum       = {1'b0, p_eff} + {1'b0, n};
    wrap      = (sum >= (PTR_W+1)'(UNITS)) ? sum - (PTR_W+1)'(UNITS) : sum;
    ptr_nxt   = wrap[PTR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_sel  <= '0;
      sel_valid <= 1'b0;
      ptr       <= '0;
      code_err  <= 1'b0;
    end else begin
      sel_valid <= sample_en;
      if (sample_en) begin
        if (dwa_en) begin
          unit_sel <= sel;
          ptr      <= ptr_nxt;
        end else begin
          unit_sel <= thermometer;
          ptr      <= p_eff;
        end
      end else if (ptr_clr) begin
        ptr <= '0;
      end
      // A clear in the same cycle as a malformed sample leaves the flag set.
      if (ptr_clr) begin
        code_err <= sample_en & malformed;
      end else if (sample_en && malformed) begin
        code_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_dwa.sv
// tb/tb_dac_dwa.sv - directed self-checking bench for dac_dwa
// Observed vector packs {unit_sel, sel_valid, ptr, code_err}.
module tb_dac_dwa;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [14:0] thermometer = '0;
  logic        dwa_en = 1'b1;
  logic        ptr_clr = 1'b0;
  logic [14:0] unit_sel;
  logic        sel_valid;
  logic [3:0]  ptr;
  logic        code_err;

  int asserts = 0;
  int fails = 0;

  dac_dwa #(.UNITS(15), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .thermometer(thermometer),
    .dwa_en(dwa_en), .ptr_clr(ptr_clr), .unit_sel(unit_sel), .sel_valid(sel_valid),
    .ptr(ptr), .code_err(code_err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] pack(input logic [14:0] u, input logic v, input logic [3:0] p, input logic e);
    return {u, v, p, e};
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic do_sample(input logic [14:0] t, input logic d, input logic c);
    sample_en = 1'b1; thermometer = t; dwa_en = d; ptr_clr = c;
    @(posedge clk); #1;
    sample_en = 1'b0; ptr_clr = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== 21'h0) begin
      $display("FAIL reset: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err), 21'h0); fails++;
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    logic [14:0] exp_u [3];
    logic [3:0]  exp_p [3];
    exp_u[0] = 15'h001F; exp_u[1] = 15'h03E0; exp_u[2] = 15'h7C00;
    exp_p[0] = 4'd5;     exp_p[1] = 4'd10;    exp_p[2] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      do_sample(15'h001F, 1'b1, 1'b0);
      asserts++;
      if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(exp_u[i], 1'b1, exp_p[i], 1'b0)) begin
        $display("FAIL rotation[%0d]: got %h required %h", i, pack(unit_sel, sel_valid, ptr, code_err),
                 pack(exp_u[i], 1'b1, exp_p[i], 1'b0)); fails++;
      end
      idle(1);
      asserts++;
      if (sel_valid !== 1'b0) begin
        $display("FAIL rotation_pulse[%0d]: got %b required 0", i, sel_valid); fails++;
      end
    end
  endtask

  task automatic test_wrap();
    do_sample(15'h03FF, 1'b1, 1'b0);
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(15'h03FF, 1'b1, 4'd10, 1'b0)) begin
      $display("FAIL wrap_setup: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err),
               pack(15'h03FF, 1'b1, 4'd10, 1'b0)); fails++;
    end
    do_sample(15'h007F, 1'b1, 1'b0);
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(15'h7C03, 1'b1, 4'd2, 1'b0)) begin
      $display("FAIL wrap: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err),
               pack(15'h7C03, 1'b1, 4'd2, 1'b0)); fails++;
    end
  endtask

  task automatic test_full_empty();
    logic [14:0] t [5];
    logic [20:0] e [5];
    t[0] = 15'h7FFF; e[0] = pack(15'h7FFF, 1'b1, 4'd2, 1'b0);
    t[1] = 15'h0000; e[1] = pack(15'h0000, 1'b1, 4'd2, 1'b0);
    t[2] = 15'h0001; e[2] = pack(15'h0004, 1'b1, 4'd3, 1'b0);
    t[3] = 15'h000F; e[3] = pack(15'h0078, 1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_sample(t[i], 1'b1, 1'b0);
      asserts++;
      if (pack(unit_sel, sel_valid, ptr, code_err) !== e[i]) begin
        $display("FAIL full_empty[%0d]: got %h required %h", i, pack(unit_sel, sel_valid, ptr, code_err), e[i]); fails++;
      end
      if (i == 2) begin
        thermometer = 15'h7FFF;
        idle(3);
        asserts++;
        if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(15'h0004, 1'b0, 4'd3, 1'b0)) begin
          $display("FAIL idle_hold: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err),
                   pack(15'h0004, 1'b0, 4'd3, 1'b0)); fails++;
        end
      end
    end
  endtask

  task automatic test_bypass();
    do_sample(15'h003F, 1'b0, 1'b0);
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(15'h003F, 1'b1, 4'd7, 1'b0)) begin
      $display("FAIL bypass: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err),
               pack(15'h003F, 1'b1, 4'd7, 1'b0)); fails++;
    end
    do_sample(15'h0007, 1'b1, 1'b0);
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(15'h0380, 1'b1, 4'd10, 1'b0)) begin
      $display("FAIL bypass_resume: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err),
               pack(15'h0380, 1'b1, 4'd10, 1'b0)); fails++;
    end
  endtask

  task automatic test_malformed();
    logic [14:0] t [6];
    logic        s [6];
    logic        c [6];
    logic [20:0] e [6];
    t[0] = 15'h0000; s[0] = 1'b0; c[0] = 1'b1; e[0] = pack(15'h0380, 1'b0, 4'd0, 1'b0);
    t[1] = 15'h0005; s[1] = 1'b1; c[1] = 1'b0; e[1] = pack(15'h0003, 1'b1, 4'd2, 1'b1);
    t[2] = 15'h0001; s[2] = 1'b1; c[2] = 1'b0; e[2] = pack(15'h0004, 1'b1, 4'd3, 1'b1);
    t[3] = 15'h000F; s[3] = 1'b1; c[3] = 1'b1; e[3] = pack(15'h000F, 1'b1, 4'd4, 1'b0);
    t[4] = 15'h0005; s[4] = 1'b1; c[4] = 1'b1; e[4] = pack(15'h0003, 1'b1, 4'd2, 1'b1);
    t[5] = 15'h0000; s[5] = 1'b0; c[5] = 1'b1; e[5] = pack(15'h0003, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sample_en = s[i]; thermometer = t[i]; dwa_en = 1'b1; ptr_clr = c[i];
      @(posedge clk); #1;
      sample_en = 1'b0; ptr_clr = 1'b0;
      asserts++;
      if (pack(unit_sel, sel_valid, ptr, code_err) !== e[i]) begin
        $display("FAIL malformed[%0d]: got %h required %h", i, pack(unit_sel, sel_valid, ptr, code_err), e[i]); fails++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_sample(15'h01FF, 1'b1, 1'b0);
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(15'h01FF, 1'b1, 4'd9, 1'b0)) begin
      $display("FAIL reset_mid_setup: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err),
               pack(15'h01FF, 1'b1, 4'd9, 1'b0)); fails++;
    end
    sample_en = 1'b1; thermometer = 15'h0003; dwa_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== 21'h0) begin
      $display("FAIL reset_async: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err), 21'h0); fails++;
    end
    @(posedge clk); #1;
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== 21'h0) begin
      $display("FAIL reset_strobe_dropped: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err), 21'h0); fails++;
    end
    sample_en = 1'b0;
    rst = 1'b0;
    do_sample(15'h0003, 1'b1, 1'b0);
    asserts++;
    if (pack(unit_sel, sel_valid, ptr, code_err) !== pack(15'h0003, 1'b1, 4'd2, 1'b0)) begin
      $display("FAIL reset_release: got %h required %h", pack(unit_sel, sel_valid, ptr, code_err),
               pack(15'h0003, 1'b1, 4'd2, 1'b0)); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_full_empty();
    test_bypass();
    test_malformed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
